// File: rtl/pattern_pwm_pkg.sv
// Shared definitions for the pattern PWM link, used by both transmitter and receiver
// so that both ends agree on frame width, bit period and decode threshold.
package pattern_pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int PAT_W_DEF      = 8;
  localparam int BIT_CYCLES_DEF = 10;
  localparam int THRESH_DEF     = 5;

endpackage

// File: rtl/pwm_edge_sync.sv
// Line conditioning for the PWM receiver: optional 2-flop synchronizer
// (PATTERN_PWM_RX_SYNC_EN) followed by a one-cycle delay for rising-edge detection.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise
);

  logic pwm_d_reg;

`ifdef PATTERN_PWM_RX_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], pwm_in};
    end
  end

  assign pwm_s = sync_reg[1];
`else
  assign pwm_s = pwm_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_d_reg <= 1'b0;
    end else begin
      pwm_d_reg <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d_reg;

endmodule

// File: rtl/pattern_pwm_rx.sv
// Pattern PWM receiver: decodes duty-cycle encoded bits, MSB first, into PAT_W-bit patterns.
// Define PATTERN_PWM_RX_SYNC_EN to synchronize pwm_in (adds 2 cycles of latency).
module pattern_pwm_rx
  import pattern_pwm_pkg::*;
#(
  parameter int PAT_W      = PAT_W_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int THRESH     = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic             pwm_in,
  output logic [PAT_W-1:0] pat_out,
  output logic             pat_valid,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_HI  = CW'(BIT_CYCLES);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

  logic pwm_s;
  logic rise;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cyc_cnt_reg, cyc_cnt_next;
  logic [CW-1:0]    hi_cnt_reg, hi_cnt_next;
  logic [BW-1:0]    bit_idx_reg, bit_idx_next;
  logic [PAT_W-1:0] shift_reg, shift_next;
  logic             done_reg, done_next;
  logic [PAT_W-1:0] pat_out_reg, pat_out_next;
  logic             pat_valid_reg, pat_valid_next;
  logic             err_det;

  logic [CW-1:0]    hi_now;
  logic             bit_val;
  logic [PAT_W:0]   shift_ext;

  pwm_edge_sync u_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .pwm_s  (pwm_s),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_reg   <= '0;
      hi_cnt_reg    <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      done_reg      <= 1'b0;
      pat_out_reg   <= '0;
      pat_valid_reg <= 1'b0;
    end else begin
      cyc_cnt_reg   <= cyc_cnt_next;
      hi_cnt_reg    <= hi_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      done_reg      <= done_next;
      pat_out_reg   <= pat_out_next;
      pat_valid_reg <= pat_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cyc_cnt_next   = cyc_cnt_reg;
    hi_cnt_next    = hi_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    done_next      = done_reg;
    pat_out_next   = pat_out_reg;
    pat_valid_next = 1'b0;
    err_det        = 1'b0;
    hi_now         = hi_cnt_reg + CW'(pwm_s);
    bit_val        = (hi_now >= THRESH_C);
    shift_ext      = {shift_reg, bit_val};

    case (state_reg)
      IDLE: begin
        cyc_cnt_next = '0;
        hi_cnt_next  = '0;
        bit_idx_next = '0;
        done_next    = 1'b0;
        // The edge cycle itself is bit cycle 0 and is already high.
        if (rx_en && rise) begin
          state_next   = RECV;
          cyc_cnt_next = CW'(1);
          hi_cnt_next  = CW'(1);
        end
      end
      RECV: begin
        if (!rx_en) begin
          state_next = IDLE;
        end else if (cyc_cnt_reg == '0) begin
          // Boundary cycle: a new bit must start here unless the frame just completed.
          if (rise) begin
            cyc_cnt_next = CW'(1);
            hi_cnt_next  = CW'(1);
            done_next    = 1'b0;
          end else begin
            state_next = IDLE;
            err_det    = !done_reg;
          end
        end else if (cyc_cnt_reg == LAST_CYC) begin
          cyc_cnt_next = '0;
          hi_cnt_next  = '0;
          if (hi_now == FULL_HI) begin
            state_next   = IDLE;
            err_det      = 1'b1;
            bit_idx_next = '0;
          end else begin
            shift_next = shift_ext[PAT_W-1:0];
            if (bit_idx_reg == LAST_BIT) begin
              pat_out_next   = shift_ext[PAT_W-1:0];
              pat_valid_next = 1'b1;
              done_next      = 1'b1;
              bit_idx_next   = '0;
            end else begin
              bit_idx_next = bit_idx_reg + BW'(1);
            end
          end
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CW'(1);
          hi_cnt_next  = hi_now;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RECV);
    err  = err_det;
  end

  assign pat_out   = pat_out_reg;
  assign pat_valid = pat_valid_reg;

endmodule

// File: tb/tb_pattern_pwm_rx.sv
// Directed and randomized bench for pattern_pwm_rx; expected patterns and event cycles
// are derived from the high-cycle count chosen for each transmitted bit.
module tb_pattern_pwm_rx;

  localparam int PAT_W = 8;
  localparam int BC    = 10;
  localparam int TH    = 5;
  localparam int FRAME = PAT_W * BC;
`ifdef PATTERN_PWM_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       pwm_in;
  logic [7:0] pat_out;
  logic       pat_valid;
  logic       busy;
  logic       err;

  pattern_pwm_rx #(.PAT_W(PAT_W), .BIT_CYCLES(BC), .THRESH(TH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .pwm_in    (pwm_in),
    .pat_out   (pat_out),
    .pat_valid (pat_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } ev_t;

  ev_t valid_q[$];
  int  err_q[$];
  int  busy_cnt = 0;
  int  overlap  = 0;

  always @(negedge clk) begin
    if (pat_valid) valid_q.push_back('{cycle, pat_out});
    if (err) err_q.push_back(cycle);
    if (busy) busy_cnt = busy_cnt + 1;
    if (err && pat_valid) overlap = overlap + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pwm_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_h(input int h);
    for (int i = 0; i < BC; i++) begin
      pwm_in = (i < h);
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] pat, input int h1, input int h0, output int s);
    s = cycle;
    for (int b = PAT_W - 1; b >= 0; b--) send_h(pat[b] ? h1 : h0);
  endtask

  function automatic logic [7:0] model_decode(input int hs[PAT_W]);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < PAT_W; i++) p = {p[6:0], (hs[i] >= TH) ? 1'b1 : 1'b0};
    return p;
  endfunction

  int         s, s2, v0, e0, b0;
  logic [7:0] p;
  int         hs[PAT_W];
  logic [7:0] exp_pat[20];
  int         exp_cyc[20];

  initial begin
    rst = 1'b1; rx_en = 1'b0; pwm_in = 1'b0;
    tick();
    repeat (3) tick();
    check("rst_pat_out", pat_out, 8'h00);
    check("rst_pat_valid", pat_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0; rx_en = 1'b1;
    idle(5);

    // Frame 0xAA: latency, single valid, busy duration
    v0 = valid_q.size(); e0 = err_q.size(); b0 = busy_cnt;
    send_frame(8'hAA, 7, 3, s);
    idle(10);
    check("aa_valid_count", valid_q.size(), v0 + 1);
    check("aa_value", valid_q[v0].val, 8'hAA);
    check("aa_latency", valid_q[v0].cyc, s + FRAME + LAT);
    check("aa_no_err", err_q.size(), e0);
    check("aa_busy_cycles", busy_cnt - b0, FRAME);

    // FF, then CC and 33 back-to-back
    v0 = valid_q.size(); e0 = err_q.size();
    send_frame(8'hFF, 7, 3, s);
    idle(4);
    send_frame(8'hCC, 7, 3, s2);
    send_frame(8'h33, 7, 3, s);
    idle(10);
    check("b2b_valid_count", valid_q.size(), v0 + 3);
    check("b2b_ff", valid_q[v0].val, 8'hFF);
    check("b2b_cc", valid_q[v0+1].val, 8'hCC);
    check("b2b_33", valid_q[v0+2].val, 8'h33);
    check("b2b_cc_latency", valid_q[v0+1].cyc, s2 + FRAME + LAT);
    check("b2b_spacing", valid_q[v0+2].cyc - valid_q[v0+1].cyc, FRAME);
    check("b2b_no_err", err_q.size(), e0);

    // Threshold boundary: H=4 -> 0, H=5 -> 1
    v0 = valid_q.size();
    send_frame(8'h55, 5, 4, s);
    idle(6);
    check("thr_55", valid_q[v0].val, 8'h55);

    // H=9 still a 1
    p = 8'($urandom());
    v0 = valid_q.size();
    send_frame(p, 9, 3, s);
    idle(6);
    check("h9_value", valid_q[v0].val, p);

    // H=10 on bit 2: stuck-high error at the last cycle of that bit
    v0 = valid_q.size(); e0 = err_q.size(); b0 = busy_cnt;
    s = cycle;
    send_h(7); send_h(3); send_h(10);
    idle(20);
    check("h10_err_count", err_q.size(), e0 + 1);
    check("h10_err_cycle", err_q[e0], s + 2 * BC + BC - 1 + LAT);
    check("h10_no_valid", valid_q.size(), v0);
    check("h10_busy_cycles", busy_cnt - b0, 2 * BC + BC - 1);
    check("h10_pat_hold", pat_out, p);

    // Missing edge at bit 3
    v0 = valid_q.size(); e0 = err_q.size(); b0 = busy_cnt;
    s = cycle;
    send_h(7); send_h(3); send_h(7);
    idle(BC + 15);
    check("noedge_err_count", err_q.size(), e0 + 1);
    check("noedge_err_cycle", err_q[e0], s + 3 * BC + LAT);
    check("noedge_busy_cycles", busy_cnt - b0, 3 * BC);
    check("noedge_no_valid", valid_q.size(), v0);
    check("noedge_pat_hold", pat_out, p);

    // rx_en drops in bit 4
    v0 = valid_q.size(); e0 = err_q.size(); b0 = busy_cnt;
    s = cycle;
    repeat (4) send_h(7);
    for (int i = 0; i < BC; i++) begin
      if (i == 2) rx_en = 1'b0;
      pwm_in = (i < 7);
      tick();
    end
    idle(15);
    rx_en = 1'b1;
    idle(3);
    check("rxen_busy_cycles", busy_cnt - b0, 4 * BC + 2 - LAT);
    check("rxen_no_err", err_q.size(), e0);
    check("rxen_no_valid", valid_q.size(), v0);
    send_frame(8'h3C, 7, 3, s);
    idle(6);
    check("rxen_3c", valid_q[v0].val, 8'h3C);
    check("rxen_3c_latency", valid_q[v0].cyc, s + FRAME + LAT);

    // rst pulse during bit 6
    v0 = valid_q.size(); e0 = err_q.size();
    repeat (6) send_h(7);
    for (int i = 0; i < BC; i++) begin
      pwm_in = (i < 3);
      rst = (i == 8);
      tick();
      if (i == 8) begin
        check("mid_rst_pat_out", pat_out, 8'h00);
        check("mid_rst_valid", pat_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
      end
    end
    rst = 1'b0;
    idle(20);
    check("mid_rst_no_valid", valid_q.size(), v0);
    check("mid_rst_no_err", err_q.size(), e0);

    // Randomized frames with random duty cycles and gaps (0 = back-to-back)
    v0 = valid_q.size(); e0 = err_q.size();
    for (int f = 0; f < 20; f++) begin
      idle($urandom_range(4, 0));
      for (int i = 0; i < PAT_W; i++)
        hs[i] = ($urandom_range(1, 0) == 1) ? $urandom_range(BC - 1, TH) : $urandom_range(TH - 1, 1);
      exp_pat[f] = model_decode(hs);
      exp_cyc[f] = cycle + FRAME + LAT;
      for (int i = 0; i < PAT_W; i++) send_h(hs[i]);
    end
    idle(10);
    check("rand_valid_count", valid_q.size(), v0 + 20);
    check("rand_no_err", err_q.size(), e0);
    for (int f = 0; f < 20 && v0 + f < valid_q.size(); f++) begin
      check($sformatf("rand_%0d_value", f), valid_q[v0+f].val, exp_pat[f]);
      check($sformatf("rand_%0d_cycle", f), valid_q[v0+f].cyc, exp_cyc[f]);
    end

    check("err_valid_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_pwm_rx.md
Name: pattern_pwm_rx

Overview:
- Receiver/decoder for the pattern PWM line. Samples a single-wire PWM stream and recovers each PAT_W-bit pattern, MSB first.
- Bit value is carried by the duty cycle of each fixed-length bit period.
- Sits on the capture side of a pattern_pwm link, either in loopback for self-test or on a remote board. Delivers decoded patterns to the DDS/control logic with a one-cycle valid strobe.

Parameters:
- PAT_W, 8, pattern width in bits (bits per frame).
- BIT_CYCLES, 10, clock cycles per bit period; must be >= 4.
- THRESH, 5, minimum high-cycle count within a bit period that decodes as 1; must satisfy 1 <= THRESH < BIT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_en  in  1  decoder enable; 0 holds the FSM in IDLE.
- pwm_in  in  1  PWM line from the transmitter.
- pat_out  out  PAT_W  last successfully decoded pattern; reset 0.
- pat_valid  out  1  one-cycle pulse when pat_out is updated; reset 0.
- busy  out  1  high while a frame is being received; reset 0.
- err  out  1  one-cycle pulse on a framing error; reset 0.

Behaviour:
- Line format:
  - Each bit is BIT_CYCLES cycles long and begins with a rising edge.
  - The line is high for the first H cycles of the period, then low for the rest.
  - Encoding is 1 when H >= THRESH and 0 when H < THRESH.
  - Bits are sent MSB first, PAT_W bits per frame.
  - Frames may be back-to-back or separated by any idle-low gap.
- Edge detect: a rising edge is pwm_s=1 and pwm_d=0, where pwm_d is pwm_s delayed by one cycle. Without the optional macro, pwm_s = pwm_in.
- FSM states:
  - IDLE:
    - busy=0; cyc_cnt, hi_cnt and bit_idx are cleared.
    - A rising edge with rx_en=1 moves to RECV.
    - The edge cycle counts as bit cycle 0, so hi_cnt=1.
  - RECV:
    - busy=1. cyc_cnt counts 0..BIT_CYCLES-1 and hi_cnt counts cycles where pwm_s=1.
    - At cyc_cnt=BIT_CYCLES-1 the bit is decided: bit = (hi_cnt_including_current >= THRESH). It is shifted into the shift register and bit_idx is incremented.
    - After the last bit (bit_idx=PAT_W-1): on the next cycle pat_out is loaded from the shift register and pat_valid=1 for exactly one cycle.
    - The FSM returns to IDLE on that same next cycle. If that cycle is also a rising edge, it is consumed as cycle 0 of a new frame, so back-to-back frames lose no cycles.
    - For bits other than the last: the cycle after the end of a bit must be a rising edge, which becomes cycle 0 of the next bit.
- Framing error: err pulses for one cycle, the FSM goes to IDLE, pat_out is unchanged and no pat_valid is issued. Causes:
  - no rising edge where the next bit period must begin;
  - hi_cnt = BIT_CYCLES in any bit (line stuck high).
- Latency: pat_valid asserts 1 cycle after the last cycle of the final bit period, i.e. PAT_W*BIT_CYCLES cycles after the initial edge cycle.
- rx_en=0 mid-frame: the next cycle goes to IDLE with busy=0 and the frame is discarded silently (no err, no valid).
- rst mid-frame: all outputs and internal state return to reset values on the next clock edge.
- Simultaneous events:
  - rst overrides rx_en, and rx_en overrides edge/decoding.
  - err and pat_valid are never high in the same cycle.
- Counter widths: $clog2(BIT_CYCLES+1) for cyc_cnt and hi_cnt; $clog2(PAT_W) for bit_idx. No wrap is possible because cyc_cnt resets every bit.

Optional Feature:
- Macro: PATTERN_PWM_RX_SYNC_EN.
- Defined:
  - pwm_in passes through a 2-flop synchronizer (reset to 0) before pwm_s, for asynchronous or off-board lines.
  - All latencies measured from pwm_in increase by 2 cycles.
- Undefined: pwm_s = pwm_in directly, for same-clock-domain loopback.

Decomposition:
- Package pattern_pwm_pkg:
  - state enum (IDLE, RECV);
  - default constants PAT_W_DEF=8, BIT_CYCLES_DEF=10, THRESH_DEF=5;
  - shared with the transmitter so both ends agree on the format.
- Sub-module pwm_edge_sync: optional 2-flop synchronizer plus one-cycle delay. Outputs pwm_s and rise.

Test Plan (BIT_CYCLES=10, THRESH=5, PAT_W=8; 1 encoded as H=7, 0 as H=3):
- Frame 8'hAA after reset with rx_en=1 -> pat_out=8'hAA; pat_valid a single pulse 80 cycles after the first edge; busy high for 80 cycles; err never asserted.
- Frame 8'hFF, then 8'hCC followed immediately by 8'h33 with no gap -> pat_out sequence FF, CC, 33; valid pulses for CC and 33 exactly 80 cycles apart.
- Threshold boundary: bits with H=4 and H=5 alternating (frame 0x55 pattern) -> decoded 8'h55; H=9 accepted as 1; H=10 -> err.
- Line held low for the whole of bit 3 (no edge) -> err pulse at the expected edge cycle; busy drops; pat_out keeps its previous value; no pat_valid.
- rx_en drops during bit 4 -> busy=0 next cycle; no err, no valid. A following clean 8'h3C frame decodes correctly.
- rst asserted for 1 cycle during bit 6 -> all outputs 0 next cycle. Repeat the 8'hAA frame with PATTERN_PWM_RX_SYNC_EN defined -> 8'hAA with latency +2.
